// File: rtl/sc_time_prescaler_pkg.sv
// Shared definitions for the game-time prescaler: state encodings, state
// width and the default tick period for a 50 MHz system clock.
package sc_time_pkg;

    localparam int STATE_W = 2;

    // ST_INVALID is never entered on purpose; it is named so the FSM can
    // recover from it explicitly.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_INVALID = 2'b11
    } state_e;

    // One tick per second at 50 MHz.
    localparam int unsigned PRESCALER_DEFAULT_50MHZ = 32'd50000000;

endpackage

// File: rtl/sc_time_prescaler_if.sv
// Button, period and tick/clear/state signals between the control logic
// (master) and the prescaler (slave).
interface sc_time_prescaler_if #(
    parameter int PRESCALER_DATAWIDTH = 26
);
    import sc_time_pkg::*;

    logic                           SC_TimePRESCALER_start_InLow;
    logic                           SC_TimePRESCALER_pause_InLow;
    logic                           SC_TimePRESCALER_stop_InLow;
    logic [PRESCALER_DATAWIDTH-1:0] SC_TimePRESCALER_period_InBUS;
    logic                           SC_TimePRESCALER_upcount_OutLow;
    logic                           SC_TimePRESCALER_clear_OutHigh;
    logic [STATE_W-1:0]             SC_TimePRESCALER_state_OutBUS;

    modport master (
        output SC_TimePRESCALER_start_InLow,
        output SC_TimePRESCALER_pause_InLow,
        output SC_TimePRESCALER_stop_InLow,
        output SC_TimePRESCALER_period_InBUS,
        input  SC_TimePRESCALER_upcount_OutLow,
        input  SC_TimePRESCALER_clear_OutHigh,
        input  SC_TimePRESCALER_state_OutBUS
    );

    modport slave (
        input  SC_TimePRESCALER_start_InLow,
        input  SC_TimePRESCALER_pause_InLow,
        input  SC_TimePRESCALER_stop_InLow,
        input  SC_TimePRESCALER_period_InBUS,
        output SC_TimePRESCALER_upcount_OutLow,
        output SC_TimePRESCALER_clear_OutHigh,
        output SC_TimePRESCALER_state_OutBUS
    );

endinterface

// File: rtl/sc_time_prescaler_edge_detector_low.sv
// Falling-edge detector for an active-low, already debounced button.
// The sample register resets to 0 ("pressed"), so a button held through
// reset produces no event until it is released and pressed again.
module sc_edge_detector_low (
    input  logic clk,
    input  logic rst,
    input  logic btn_in_low,
    output logic fall_evt
);

    logic sample_q;
    logic sample_d;

    // Next sample is simply the current button level.
    always_comb begin
        sample_d = btn_in_low;
    end

    // Previous-sample register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= 1'b0;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign fall_evt = ~btn_in_low & sample_q;

endmodule

// File: rtl/sc_time_prescaler.sv
// Game-time tick generator: divides the system clock into one-cycle
// active-low upcount strobes with a period latched at start, under a
// start/pause/stop state machine, and pulses clear at each new game.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no game running; count held at 0; waits for a start event
// ST_RUN   | count advances each cycle; tick when it wraps at P-1
// ST_PAUSE | count frozen, no ticks; pause resumes, stop ends the game
// ST_INVALID | unreachable; falls back to ST_IDLE on the next cycle
module sc_time_prescaler
    import sc_time_pkg::*;
#(
    parameter int          PRESCALER_DATAWIDTH = 26,
    parameter int unsigned PRESCALER_DEFAULT   = PRESCALER_DEFAULT_50MHZ
) (
    input  logic                SC_TimePRESCALER_CLOCK_50,
    input  logic                SC_TimePRESCALER_RESET_InHigh,
    sc_time_prescaler_if.slave  bus
);

    localparam int W = PRESCALER_DATAWIDTH;
    localparam logic [W-1:0] DEFAULT_P = W'(PRESCALER_DEFAULT);
    localparam logic [W-1:0] ONE       = W'(1);

    logic clk;
    logic rst;

    assign clk = SC_TimePRESCALER_CLOCK_50;
    assign rst = SC_TimePRESCALER_RESET_InHigh;

    logic start_evt;
    logic pause_evt;
    logic stop_evt;

    sc_edge_detector_low u_start_edge (
        .clk        (clk),
        .rst        (rst),
        .btn_in_low (bus.SC_TimePRESCALER_start_InLow),
        .fall_evt   (start_evt)
    );

    sc_edge_detector_low u_pause_edge (
        .clk        (clk),
        .rst        (rst),
        .btn_in_low (bus.SC_TimePRESCALER_pause_InLow),
        .fall_evt   (pause_evt)
    );

    sc_edge_detector_low u_stop_edge (
        .clk        (clk),
        .rst        (rst),
        .btn_in_low (bus.SC_TimePRESCALER_stop_InLow),
        .fall_evt   (stop_evt)
    );

    state_e         state_q,   state_d;
    logic [W-1:0]   count_q,   count_d;
    logic [W-1:0]   period_q,  period_d;
    logic           upcount_q, upcount_d;
    logic           clear_q,   clear_d;

    // Next-state, counter, period latch and registered-output values.
    // Stop outranks pause, pause outranks start; a pause on the wrap edge
    // freezes the count at P-1 so the tick fires on the first RUN edge
    // after resume.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        period_d  = period_q;
        upcount_d = 1'b1;
        clear_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (start_evt) begin
                    state_d  = ST_RUN;
                    clear_d  = 1'b1;
                    period_d = (bus.SC_TimePRESCALER_period_InBUS == '0)
                               ? DEFAULT_P
                               : bus.SC_TimePRESCALER_period_InBUS;
                end
            end

            ST_RUN: begin
                if (stop_evt) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (pause_evt) begin
                    state_d = ST_PAUSE;
                end else if (count_q == period_q - ONE) begin
                    count_d   = '0;
                    upcount_d = 1'b0;
                end else begin
                    count_d = count_q + ONE;
                end
            end

            ST_PAUSE: begin
                if (stop_evt) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                end else if (pause_evt) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    // State, counter, period and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            period_q  <= DEFAULT_P;
            upcount_q <= 1'b1;
            clear_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            period_q  <= period_d;
            upcount_q <= upcount_d;
            clear_q   <= clear_d;
        end
    end

    assign bus.SC_TimePRESCALER_upcount_OutLow = upcount_q;
    assign bus.SC_TimePRESCALER_clear_OutHigh  = clear_q;
    assign bus.SC_TimePRESCALER_state_OutBUS   = state_q;

endmodule

// File: tb/tb_sc_time_prescaler.sv
// Bench for sc_time_prescaler: directed scenarios followed by random button
// traffic, every cycle compared against a behavioural model that counts
// elapsed RUN cycles since start and expects a tick whenever that count
// reaches a multiple of the latched period.
module tb_sc_time_prescaler;

    localparam int DW  = 26;
    localparam int DEF = 37;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sc_time_prescaler_if #(.PRESCALER_DATAWIDTH(DW)) bus ();

    sc_time_prescaler #(
        .PRESCALER_DATAWIDTH (DW),
        .PRESCALER_DEFAULT   (DEF)
    ) dut (
        .SC_TimePRESCALER_CLOCK_50     (clk),
        .SC_TimePRESCALER_RESET_InHigh (rst),
        .bus                           (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model state: 0 idle, 1 run, 2 pause
    int m_state  = 0;
    int m_period = DEF;
    int m_run_n  = 0;
    bit m_prev_s = 0, m_prev_p = 0, m_prev_t = 0;
    bit m_up     = 1;
    bit m_clr    = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        bit sev, pev, tev;
        if (rst) begin
            m_state  = 0;
            m_prev_s = 0;
            m_prev_p = 0;
            m_prev_t = 0;
            m_up     = 1;
            m_clr    = 0;
            m_run_n  = 0;
        end else begin
            sev = !bus.SC_TimePRESCALER_start_InLow && m_prev_s;
            pev = !bus.SC_TimePRESCALER_pause_InLow && m_prev_p;
            tev = !bus.SC_TimePRESCALER_stop_InLow  && m_prev_t;
            m_prev_s = bus.SC_TimePRESCALER_start_InLow;
            m_prev_p = bus.SC_TimePRESCALER_pause_InLow;
            m_prev_t = bus.SC_TimePRESCALER_stop_InLow;
            m_up  = 1;
            m_clr = 0;
            case (m_state)
                0: if (sev) begin
                    m_state  = 1;
                    m_period = (bus.SC_TimePRESCALER_period_InBUS == 0) ? DEF
                               : int'(bus.SC_TimePRESCALER_period_InBUS);
                    m_run_n  = 0;
                    m_clr    = 1;
                end
                1: if (tev) m_state = 0;
                   else if (pev) m_state = 2;
                   else begin
                       m_run_n++;
                       if (m_run_n % m_period == 0) m_up = 0;
                   end
                2: if (tev) m_state = 0;
                   else if (pev) m_state = 1;
                default: m_state = 0;
            endcase
        end
    endtask

    // One clock: advance the model at the edge, compare just after it.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("state",   32'(bus.SC_TimePRESCALER_state_OutBUS),   32'(m_state));
        check_eq("upcount", 32'(bus.SC_TimePRESCALER_upcount_OutLow), 32'(m_up));
        check_eq("clear",   32'(bus.SC_TimePRESCALER_clear_OutHigh),  32'(m_clr));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Count cycles until the next upcount strobe; -1 if none within limit.
    task automatic cycles_to_tick(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (bus.SC_TimePRESCALER_upcount_OutLow == 1'b0) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic press_start();
        bus.SC_TimePRESCALER_start_InLow = 1'b0; tick();
        bus.SC_TimePRESCALER_start_InLow = 1'b1;
    endtask
    task automatic press_pause();
        bus.SC_TimePRESCALER_pause_InLow = 1'b0; tick();
        bus.SC_TimePRESCALER_pause_InLow = 1'b1;
    endtask
    task automatic press_stop();
        bus.SC_TimePRESCALER_stop_InLow = 1'b0; tick();
        bus.SC_TimePRESCALER_stop_InLow = 1'b1;
    endtask

    initial begin
        int n;
        int lows;
        logic ups [1:12];

        bus.SC_TimePRESCALER_start_InLow  = 1'b1;
        bus.SC_TimePRESCALER_pause_InLow  = 1'b1;
        bus.SC_TimePRESCALER_stop_InLow   = 1'b1;
        bus.SC_TimePRESCALER_period_InBUS = '0;

        // reset
        rst = 1'b1;
        ticks(3);
        check_eq("rst_state",   32'(bus.SC_TimePRESCALER_state_OutBUS), 0);
        check_eq("rst_upcount", 32'(bus.SC_TimePRESCALER_upcount_OutLow), 1);
        check_eq("rst_clear",   32'(bus.SC_TimePRESCALER_clear_OutHigh), 0);
        rst = 1'b0;
        bus.SC_TimePRESCALER_period_InBUS = 26'd4;
        ticks(2);

        // start with P=4: ticks at 4, 8, 12 cycles after acceptance
        press_start();
        check_eq("start_clear", 32'(bus.SC_TimePRESCALER_clear_OutHigh), 1);
        check_eq("start_state", 32'(bus.SC_TimePRESCALER_state_OutBUS), 1);
        lows = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            ups[i] = bus.SC_TimePRESCALER_upcount_OutLow;
            if (ups[i] == 1'b0) lows++;
        end
        check_eq("tick_at_4",  32'(ups[4]), 0);
        check_eq("tick_at_8",  32'(ups[8]), 0);
        check_eq("tick_at_12", 32'(ups[12]), 0);
        check_eq("tick_count", 32'(lows), 3);

        // advance count to 2, pause for ten cycles, resume: tick 2 later
        ticks(2);
        press_pause();
        check_eq("pause_state", 32'(bus.SC_TimePRESCALER_state_OutBUS), 2);
        ticks(10);
        press_pause();
        cycles_to_tick(20, n);
        check_eq("resume_lat", 32'(n), 2);

        // stop and pause together in RUN: stop wins
        ticks(1);
        bus.SC_TimePRESCALER_pause_InLow = 1'b0;
        press_stop();
        bus.SC_TimePRESCALER_pause_InLow = 1'b1;
        check_eq("stop_pri", 32'(bus.SC_TimePRESCALER_state_OutBUS), 0);
        ticks(2);

        // period 0 selects the default period
        bus.SC_TimePRESCALER_period_InBUS = '0;
        press_start();
        cycles_to_tick(100, n);
        check_eq("default_lat", 32'(n), DEF);
        press_stop();

        // start held through reset release produces no event
        bus.SC_TimePRESCALER_start_InLow = 1'b0;
        rst = 1'b1;
        ticks(2);
        rst = 1'b0;
        ticks(3);
        check_eq("held_start", 32'(bus.SC_TimePRESCALER_state_OutBUS), 0);
        bus.SC_TimePRESCALER_start_InLow = 1'b1;
        tick();
        bus.SC_TimePRESCALER_period_InBUS = 26'd1;
        press_start();
        check_eq("restart", 32'(bus.SC_TimePRESCALER_state_OutBUS), 1);

        // P=1: strobe every RUN cycle, then reset mid-RUN
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.SC_TimePRESCALER_upcount_OutLow == 1'b0) lows++;
        end
        check_eq("p1_ticks", 32'(lows), 5);
        rst = 1'b1;
        tick();
        check_eq("midrst_up",    32'(bus.SC_TimePRESCALER_upcount_OutLow), 1);
        check_eq("midrst_state", 32'(bus.SC_TimePRESCALER_state_OutBUS), 0);
        rst = 1'b0;
        ticks(2);

        // start during RUN is ignored and does not reload the period
        bus.SC_TimePRESCALER_period_InBUS = 26'd4;
        press_start();
        ticks(1);
        bus.SC_TimePRESCALER_period_InBUS = 26'd7;
        press_start();
        check_eq("ign_clear", 32'(bus.SC_TimePRESCALER_clear_OutHigh), 0);
        cycles_to_tick(20, n);
        check_eq("ign_period", 32'(n), 2);
        cycles_to_tick(20, n);
        check_eq("kept_period", 32'(n), 4);

        // random button traffic against the model
        for (int i = 0; i < 4000; i++) begin
            bus.SC_TimePRESCALER_start_InLow  = ($urandom_range(7) != 0);
            bus.SC_TimePRESCALER_pause_InLow  = ($urandom_range(15) != 0);
            bus.SC_TimePRESCALER_stop_InLow   = ($urandom_range(49) != 0);
            bus.SC_TimePRESCALER_period_InBUS = DW'($urandom_range(6));
            rst = ($urandom_range(399) == 0);
            tick();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
